// File: rtl/mcpu_ram_controller.sv
// Unified data/instruction RAM for the MCPU: one synchronous write port,
// one gated combinational data read port and an always-on fetch read port.
module mcpu_ram_controller #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [WORD_SIZE-1:0]  datawr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_SIZE-1:0]  datard,
  input  logic [ADDR_WIDTH-1:0] instraddr,
  output logic [WORD_SIZE-1:0]  instrrd
);

  logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

  // Reset wipes the whole array; an unknown we falls through as no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= datawr;
    end
  end

  // No write-through bypass: reads see the pre-edge contents until the edge.
  assign datard  = re ? mem[addr] : '0;
  assign instrrd = mem[instraddr];

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Self-checking bench for mcpu_ram_controller: a reference image of the
// array produces expected values that are queued at drive time and popped on compare.
module tb_mcpu_ram_controller;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [7:0] datawr;
  logic       re;
  logic [7:0] addr;
  logic [7:0] datard;
  logic [7:0] instraddr;
  logic [7:0] instrrd;

  int errs;
  int checks;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  mcpu_ram_controller dut (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .datawr(datawr),
    .re(re),
    .addr(addr),
    .datard(datard),
    .instraddr(instraddr),
    .instrrd(instrrd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    datawr = d;
    model[a] = d;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_val("wr_mem", dut.mem[a], exp_q.pop_front());
  endtask

  task automatic rd(input logic [7:0] a, input logic r);
    addr = a;
    re = r;
    exp_q.push_back(r ? model[a] : 8'h00);
    #1;
    check_val("datard", datard, exp_q.pop_front());
  endtask

  task automatic fetch(input logic [7:0] a);
    instraddr = a;
    exp_q.push_back(model[a]);
    #1;
    check_val("instrrd", instrrd, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0] a8;
    errs = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rst_n = 1'b1;
    we = 1'b0;
    re = 1'b0;
    datawr = 8'h00;
    addr = 8'h00;
    instraddr = 8'h00;
    #2;
    rst_n = 1'b0;
    re = 1'b1;
    instraddr = 8'hFF;
    #1;
    rd(8'h00, 1'b1);
    fetch(8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // fill with alternating 44/56
    for (int i = 0; i < 256; i++) begin
      a8 = 8'(i);
      wr(a8, (i % 2 == 0) ? 8'd44 : 8'd56);
    end
    for (int i = 0; i < 256; i++) begin
      a8 = 8'(i);
      rd(a8, 1'b1);
      check_val("fill_pattern", datard, (i % 2 == 0) ? 8'd44 : 8'd56);
      fetch(a8);
    end

    // re gating without any clock
    @(negedge clk);
    rd(8'h01, 1'b1);
    rd(8'h01, 1'b0);
    rd(8'h01, 1'b1);

    // read during write, same address on both ports
    wr(8'h10, 8'h11);
    @(negedge clk);
    we = 1'b1;
    addr = 8'h10;
    datawr = 8'hA5;
    re = 1'b1;
    instraddr = 8'h10;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h11);
    #1;
    check_val("rdw_data_before", datard, exp_q.pop_front());
    check_val("rdw_instr_before", instrrd, exp_q.pop_front());
    model[8'h10] = 8'hA5;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_val("rdw_data_after", datard, exp_q.pop_front());
    check_val("rdw_instr_after", instrrd, exp_q.pop_front());

    // write disabled
    @(negedge clk);
    we = 1'b0;
    addr = 8'h20;
    datawr = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_val("we0_mem", dut.mem[8'h20], model[8'h20]);
    rd(8'h20, 1'b1);

    // unknown write enable must not write
    @(negedge clk);
    we = 1'bx;
    addr = 8'h21;
    datawr = 8'h99;
    @(posedge clk);
    #1;
    we = 1'b0;
    check_val("wex_mem", dut.mem[8'h21], model[8'h21]);

    // address wrap 0xFF+1 reads word 0
    wr(8'h00, 8'h3C);
    a8 = 8'hFF;
    a8 = a8 + 8'd1;
    rd(a8, 1'b1);
    fetch(a8);

    // reset mid-operation with we held high
    @(negedge clk);
    we = 1'b1;
    addr = 8'h30;
    datawr = 8'h77;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    #1;
    for (int i = 0; i < 256; i++) check_val("reset_clear", dut.mem[i], 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_blocks_wr", dut.mem[8'h30], 8'h00);
    rd(8'h30, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model[8'h30] = 8'h77;
    exp_q.push_back(8'h77);
    @(posedge clk);
    #1;
    we = 1'b0;
    check_val("post_reset_wr", dut.mem[8'h30], exp_q.pop_front());
    rd(8'h30, 1'b1);
    fetch(8'h30);
    fetch(8'h31);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_ram_controller.md
Name: mcpu_ram_controller

Overview:
- Unified data/instruction RAM for the MCPU.
- Provides one synchronous write port and one read port on the data side, plus an independent, always-enabled instruction fetch read port.
- Sits between the CPU core (load/store unit and fetch unit) and the single storage array.
- Storage is a flat word-addressed memory with no wait states.

Parameters:
- WORD_SIZE, 8, width of each memory word and of all data buses.
- ADDR_WIDTH, 8, width of the data and instruction address buses.
- RAM_SIZE, 1<<ADDR_WIDTH (256), number of words in the array.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  data write enable, sampled on rising clk.
- datawr  input  WORD_SIZE  data to write at addr.
- re  input  1  data read enable.
- addr  input  ADDR_WIDTH  data-port address, shared by read and write.
- datard  output  WORD_SIZE  data-port read result.
- instraddr  input  ADDR_WIDTH  instruction fetch address.
- instrrd  output  WORD_SIZE  instruction word at instraddr.

Port order for positional instantiation: clk, rst_n, we, datawr, re, addr, datard, instraddr, instrrd.

Behaviour:
- Storage:
  - Array of RAM_SIZE words of WORD_SIZE bits.
  - The array is named mem, indexed mem[0..RAM_SIZE-1], so benches can read it hierarchically.
- Reset (rst_n low):
  - Asynchronously clears every mem entry to 0.
  - Writes are blocked while reset is asserted.
  - Outputs follow the cleared contents: datard = 0 when re=1, instrrd = 0.
  - Normal operation resumes at the first rising clk after rst_n returns high.
- Write:
  - On rising clk with rst_n=1 and we=1: mem[addr] <= datawr.
  - Latency is 1 edge; the new contents are visible immediately after that edge.
  - we=0 leaves memory unchanged.
- Data read (combinational):
  - datard = mem[addr] when re=1.
  - datard = 0 when re=0.
  - No clock latency; datard tracks addr and re changes within the same delta cycle.
- Instruction read (combinational, always enabled): instrrd = mem[instraddr] at all times.
- Read-during-write, same address (data or instruction port):
  - Before the edge, the read shows the old contents.
  - After the edge, it shows the new contents.
  - There is no write-through bypass.
- we and re both high: legal. The write completes at the edge; datard reflects the written value afterward.
- The data and instruction ports may address the same or different words simultaneously with no conflict.
- Addresses:
  - Full ADDR_WIDTH range is valid, no out-of-range condition.
  - Address arithmetic wraps in callers; 255+1 arrives as 0 and must read mem[0].
- X/undefined we treats the write as not performed; mem is unchanged.
- No internal state other than mem. No FSM.

Test Plan:
- Reset then read: pulse rst_n low, set re=1, addr=0x00 and instraddr=0xFF -> datard=0x00, instrrd=0x00.
- Fill pattern: for i=0..255 write datawr=44 (even i) or 56 (odd i) with we=1 for one clk -> after each edge mem[i] equals the written value. Then re=1 sweeping addr 0..255 -> datard alternates 44/56, and instrrd with instraddr sweeping matches the same pattern.
- re gating: addr=0x01 holding 56, toggle re 1->0->1 -> datard 56, 0, 56 with no clock needed.
- Read-during-write: mem[0x10]=0x11; set we=1, addr=0x10, datawr=0xA5, re=1, instraddr=0x10 -> datard and instrrd read 0x11 before the edge and 0xA5 after it.
- Write disabled: we=0, datawr=0xFF, clock 3 edges at addr=0x20 -> mem[0x20] unchanged.
- Reset mid-operation: after the fill, assert rst_n low between edges with we=1 -> all mem entries 0 immediately, no write on the following edges while rst_n=0. After release, the first write lands.
